sqsc_ts_pipe: RTL and testbench
===============================

Name: sqsc_ts_pipe

Overview:
- Masked, pipelined, multi-lane GF(2^4) square-scale unit for the threshold-implementation AES S-box datapath. It generalises the single-nibble, 2-share combinational square-scale.
- Each of SHARES shares of each of LANES nibbles is transformed independently; this is valid because the map is GF(2)-linear.
- Sits between the GF(2^4) share adders and the masked GF(2^4) inverter. It adds DEPTH register stages with valid/ready flow control, a per-transaction bypass mode and a transaction counter.

Parameters:
- SHARES, 2, number of Boolean shares per nibble (>=2).
- LANES, 1, independent nibbles per transaction (>=1).
- DEPTH, 1, pipeline register stages (>=1); equals latency with no stall.
- CNT_W, 16, width of completed-transaction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_mode  in  1  0 = square-scale, 1 = bypass (identity).
- in_data  in  SHARES*LANES*4  share s, lane l nibble at bits [(s*LANES+l)*4 +: 4].
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SHARES*LANES*4  same packing as in_data.
- done_cnt  out  CNT_W  count of output handshakes.
- rnd  in  (SHARES-1)*LANES*4  refresh randomness; present only with MASK_REFRESH_EN.

Behaviour:
- Nibble function f(x), x = {x3,x2,x1,x0}:
  - a1 = x3^x1, a0 = x2^x0.
  - f(x) = {a0, a1, x1^x0, x0}.
  - Examples: f(4'hB) = 4'h9; f(4'hF) = 4'h1; f(0) = 0.
- Computation:
  - Mode 0 applies f to every share nibble individually. Shares are never combined.
  - Mode 1 passes nibbles unchanged.
  - f is applied combinationally before stage-0 registers. Stages 1..DEPTH-1 only carry data plus valid.
- Pipeline:
  - Stage k holds v[k] and data[k].
  - Stage k loads when !v[k] || advance[k+1]. The last stage advances on out_ready.
  - in_ready = !v[0] || advance[1]. in_ready is combinational from out_ready.
  - Accept occurs on in_valid && in_ready. out_valid = v[DEPTH-1]; out_data = data[DEPTH-1].
  - Bubbles collapse: an empty stage always loads from the stage before it.
- Latency and throughput:
  - Accept at cycle t gives out_valid at t+DEPTH when there is no stall.
  - Sustained throughput is 1 transaction per cycle with out_ready held high.
- Stall: with out_ready = 0, out_valid and out_data hold stable until the handshake; nothing is dropped or duplicated.
- Full: all DEPTH stages valid and out_ready = 0 -> in_ready = 0.
- Simultaneous accept and output handshake with a full pipe: both occur in the same cycle; occupancy is unchanged.
- Reset:
  - All v[k] = 0, data = 0, done_cnt = 0, out_valid = 0.
  - in_ready = 1 one cycle after RSTn deasserts; it is 0 while RSTn = 0.
  - Assertion mid-operation discards in-flight transactions immediately (asynchronous).
- done_cnt increments by 1 per out_valid && out_ready. It wraps modulo 2^CNT_W and saturates never.
- Data registers update only when their stage loads. No clock gating. No glitchy share mixing: each register holds one share only.

Optional Feature:
- Macro: SQSC_MASK_REFRESH_EN.
- Defined:
  - rnd port exists and is sampled on accept.
  - For each lane, share s < SHARES-1 is XORed with rnd nibble (s*LANES+l).
  - The last share is XORed with the XOR of all rnd nibbles of that lane.
  - Refresh is applied after f, before stage 0.
  - The unshared value is unchanged; individual shares differ.
- Undefined: rnd port absent; shares propagate without refresh.

Test Plan:
- SHARES=2, LANES=1, DEPTH=1, mode 0, shares 4'h5/4'hE (x=B) -> out shares 4'h3/4'hA one cycle later; XOR = 4'h9.
- Mode 1, shares 4'h5/4'hE -> out shares 4'h5/4'hE unchanged.
- DEPTH=3, LANES=2:
  - 10 back-to-back transactions with out_ready = 1 -> first out_valid 3 cycles after first accept; 10 outputs on consecutive cycles; done_cnt = 10.
  - Hold out_ready = 0 for 5 cycles while feeding -> in_ready drops after 3 accepts; out_data stable; no loss or reordering after release.
- RSTn pulse low with 2 transactions in flight -> out_valid = 0 and done_cnt = 0 immediately; no stale output after release.
- With SQSC_MASK_REFRESH_EN, SHARES=3, rnd = all 4'hA, x = 4'hF -> output shares differ from the unrefreshed case; XOR of shares = 4'h1.

Source files
------------

// File: rtl/sqsc_ts_pipe.sv
// rtl/sqsc_ts_pipe.sv - masked multi-lane GF(2^4) square-scale with DEPTH-stage valid/ready pipeline
// Optional share refresh: SQSC_MASK_REFRESH_EN
module sqsc_ts_pipe #(
  parameter int SHARES = 2,
  parameter int LANES  = 1,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [SHARES*LANES*4-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SHARES*LANES*4-1:0]    out_data,
`ifdef SQSC_MASK_REFRESH_EN
  input  logic [(SHARES-1)*LANES*4-1:0] rnd,
`endif
  output logic [CNT_W-1:0]             done_cnt
);

  localparam int W = SHARES * LANES * 4;

  function automatic logic [3:0] sq_scale(input logic [3:0] x);
    return {x[2] ^ x[0], x[3] ^ x[1], x[1] ^ x[0], x[0]};
  endfunction

  logic [W-1:0]     stage_in;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic [W-1:0]     data [DEPTH];
  logic             rdy_en;

  // f is linear, so each share nibble is transformed on its own and never combined
  always_comb begin
    stage_in = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        if (in_mode)
          stage_in[(s*LANES+l)*4 +: 4] = in_data[(s*LANES+l)*4 +: 4];
        else
          stage_in[(s*LANES+l)*4 +: 4] = sq_scale(in_data[(s*LANES+l)*4 +: 4]);
      end
    end
`ifdef SQSC_MASK_REFRESH_EN
    for (int l = 0; l < LANES; l++) begin
      logic [3:0] acc;
      acc = '0;
      for (int s = 0; s < SHARES-1; s++) begin
        stage_in[(s*LANES+l)*4 +: 4] = stage_in[(s*LANES+l)*4 +: 4] ^ rnd[(s*LANES+l)*4 +: 4];
        acc = acc ^ rnd[(s*LANES+l)*4 +: 4];
      end
      stage_in[((SHARES-1)*LANES+l)*4 +: 4] = stage_in[((SHARES-1)*LANES+l)*4 +: 4] ^ acc;
    end
`endif
  end

  // A stage may load unless it and every stage after it is full while the sink stalls.
  always_comb begin
    load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic tail_full;
      tail_full = 1'b1;
      for (int j = k; j < DEPTH; j++)
        tail_full = tail_full & v[j];
      load[k] = out_ready | ~tail_full;
    end
  end

  assign in_ready  = load[0] & rdy_en;
  assign out_valid = v[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      rdy_en <= 1'b0;
    else
      rdy_en <= 1'b1;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          v[0]    <= 1'b0;
          data[0] <= '0;
        end else if (load[0]) begin
          v[0] <= in_valid & rdy_en;
          if (in_valid && rdy_en)
            data[0] <= stage_in;
        end
      end
    end else begin : g_rest
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          v[k]    <= 1'b0;
          data[k] <= '0;
        end else if (load[k]) begin
          v[k] <= v[k-1];
          if (v[k-1])
            data[k] <= data[k-1];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      done_cnt <= '0;
    else if (out_valid && out_ready)
      done_cnt <= done_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sqsc_ts_pipe.sv
// tb/tb_sqsc_ts_pipe.sv - directed self-checking bench for sqsc_ts_pipe
module tb_sqsc_ts_pipe;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_out_data;
  logic [15:0] a_done_cnt;

  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [15:0] b_done_cnt;

`ifdef SQSC_MASK_REFRESH_EN
  logic [3:0]  a_rnd;
  logic [7:0]  b_rnd;
  logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready;
  logic [11:0] c_in_data, c_out_data;
  logic [15:0] c_done_cnt;
  logic [7:0]  c_rnd;
`endif

  sqsc_ts_pipe #(.SHARES(2), .LANES(1), .DEPTH(1), .CNT_W(16)) u_a (
    .CLK(clk), .RSTn(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef SQSC_MASK_REFRESH_EN
    .rnd(a_rnd),
`endif
    .done_cnt(a_done_cnt)
  );

  sqsc_ts_pipe #(.SHARES(2), .LANES(2), .DEPTH(3), .CNT_W(16)) u_b (
    .CLK(clk), .RSTn(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
`ifdef SQSC_MASK_REFRESH_EN
    .rnd(b_rnd),
`endif
    .done_cnt(b_done_cnt)
  );

`ifdef SQSC_MASK_REFRESH_EN
  sqsc_ts_pipe #(.SHARES(3), .LANES(1), .DEPTH(1), .CNT_W(16)) u_c (
    .CLK(clk), .RSTn(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(c_in_mode), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .rnd(c_rnd),
    .done_cnt(c_done_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] f_nib(input logic [3:0] x);
    return {x[2] ^ x[0], x[3] ^ x[1], x[1] ^ x[0], x[0]};
  endfunction

  function automatic logic [15:0] b_exp(input logic [15:0] d, input logic m);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = m ? d[i*4 +: 4] : f_nib(d[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] b_vec(input int i);
    return 16'h1234 + 16'(i) * 16'h1111 + 16'(i * i * 7);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_vec++;
    if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    n_vec++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b/%b want 0/0", a_out_valid, b_out_valid);
    end
    n_vec++;
    if (a_out_data !== 8'h00 || b_done_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_state: got data %h cnt %0d want 00/0", a_out_data, b_done_cnt);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_delay: got %b want 0", b_in_ready); end
    @(posedge clk); #3;
    n_vec++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b/%b want 1/1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_square;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 8'hE5; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    n_vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'hA3) begin
      n_err++; $display("FAIL square_out: got v=%b %h want v=1 a3", a_out_valid, a_out_data);
    end
    n_vec++;
    if ((a_out_data[7:4] ^ a_out_data[3:0]) !== 4'h9) begin
      n_err++; $display("FAIL square_xor: got %h want 9", a_out_data[7:4] ^ a_out_data[3:0]);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #2;
    n_vec++;
    if (a_out_valid !== 1'b0 || a_done_cnt !== 16'd1) begin
      n_err++; $display("FAIL square_drain: got v=%b cnt=%0d want v=0 cnt=1", a_out_valid, a_done_cnt);
    end
  endtask

  task automatic test_bypass;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = 8'hE5; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    n_vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'hE5) begin
      n_err++; $display("FAIL bypass_out: got v=%b %h want v=1 e5", a_out_valid, a_out_data);
    end
    @(posedge clk); #2;
    n_vec++;
    if (a_done_cnt !== 16'd2) begin n_err++; $display("FAIL bypass_cnt: got %0d want 2", a_done_cnt); end
  endtask

  task automatic test_back_to_back;
    int n_out;
    n_out = 0;
    b_out_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      @(posedge clk); #1;
      b_in_valid = (s < 10);
      b_in_data  = b_vec(s);
      b_in_mode  = 1'(s & 1);
      #2;
      if (s < 10) begin
        n_vec++;
        if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready s=%0d: got %b want 1", s, b_in_ready); end
      end
      n_vec++;
      if (b_out_valid !== (s >= 3 && s < 13)) begin
        n_err++; $display("FAIL b2b_out_valid s=%0d: got %b want %b", s, b_out_valid, (s >= 3 && s < 13));
      end else if (b_out_valid) begin
        n_out++;
        n_vec++;
        if (b_out_data !== b_exp(b_vec(s-3), 1'((s-3) & 1))) begin
          n_err++; $display("FAIL b2b_data s=%0d: got %h want %h", s, b_out_data, b_exp(b_vec(s-3), 1'((s-3) & 1)));
        end
      end
    end
    n_vec++;
    if (b_done_cnt !== 16'd10 || n_out != 10) begin
      n_err++; $display("FAIL b2b_count: got cnt=%0d outs=%0d want 10/10", b_done_cnt, n_out);
    end
  endtask

  task automatic test_stall;
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int sent, got, cyc;
    sent = 0; got = 0;
    b_out_ready = 1'b0;
    b_in_mode   = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      b_in_data  = b_vec(20 + sent);
      #2;
      n_vec++;
      if (b_in_ready !== (s < 3)) begin
        n_err++; $display("FAIL stall_in_ready s=%0d: got %b want %b", s, b_in_ready, (s < 3));
      end
      if (s >= 3) begin
        n_vec++;
        if (b_out_valid !== 1'b1 || b_out_data !== b_exp(b_vec(20), 1'b0)) begin
          n_err++; $display("FAIL stall_hold s=%0d: got v=%b %h want v=1 %h", s, b_out_valid, b_out_data, b_exp(b_vec(20), 1'b0));
        end
      end
      if (b_in_ready) begin
        exp_q.push_back(b_exp(b_in_data, 1'b0));
        sent++;
      end
    end
    b_out_ready = 1'b1;
    cyc = 0;
    while (got < 6 && cyc < 30) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      b_in_valid = (sent < 6);
      b_in_data  = b_vec(20 + sent);
      #2;
      if (cyc == 0) begin
        n_vec++;
        if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_full_pass: got %b want 1", b_in_ready); end
      end
      if (b_out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_vec++;
        if (b_out_data !== e) begin
          n_err++; $display("FAIL stall_order #%0d: got %h want %h", got, b_out_data, e);
        end
        got++;
      end
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(b_exp(b_in_data, 1'b0));
        sent++;
      end
      cyc++;
    end
    b_in_valid = 1'b0;
    @(posedge clk); #3;
    n_vec++;
    if (got != 6 || b_done_cnt !== 16'd16 || exp_q.size() != 0) begin
      n_err++; $display("FAIL stall_total: got outs=%0d cnt=%0d left=%0d want 6/16/0", got, b_done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    b_out_ready = 1'b0;
    b_in_mode   = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      b_in_data  = b_vec(40 + s);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    #2;
    n_vec++;
    if (b_out_valid !== 1'b1 || b_done_cnt !== 16'd16) begin
      n_err++; $display("FAIL midflight_pre: got v=%b cnt=%0d want v=1 cnt=16", b_out_valid, b_done_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (b_out_valid !== 1'b0 || b_done_cnt !== 16'd0 || b_in_ready !== 1'b0) begin
      n_err++; $display("FAIL midflight_reset: got v=%b cnt=%0d rdy=%b want 0/0/0", b_out_valid, b_done_cnt, b_in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #3;
      n_vec++;
      if (b_out_valid !== 1'b0 || b_done_cnt !== 16'd0) begin
        n_err++; $display("FAIL midflight_stale s=%0d: got v=%b cnt=%0d want 0/0", s, b_out_valid, b_done_cnt);
      end
    end
  endtask

`ifdef SQSC_MASK_REFRESH_EN
  task automatic test_refresh;
    @(posedge clk); #1;
    c_in_valid = 1'b1; c_in_mode = 1'b0; c_in_data = 12'h953; c_rnd = 8'hAA; c_out_ready = 1'b0;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    #1;
    n_vec++;
    if (c_out_valid !== 1'b1 || c_out_data !== 12'hF97) begin
      n_err++; $display("FAIL refresh_shares: got v=%b %h want v=1 f97", c_out_valid, c_out_data);
    end
    n_vec++;
    if ((c_out_data[11:8] ^ c_out_data[7:4] ^ c_out_data[3:0]) !== 4'h1) begin
      n_err++; $display("FAIL refresh_xor: got %h want 1", c_out_data[11:8] ^ c_out_data[7:4] ^ c_out_data[3:0]);
    end
    c_out_ready = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0;
    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1;
`ifdef SQSC_MASK_REFRESH_EN
    a_rnd = '0; b_rnd = '0;
    c_in_valid = 0; c_in_mode = 0; c_in_data = '0; c_out_ready = 1; c_rnd = '0;
`endif
    test_reset();
    test_square();
    test_bypass();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef SQSC_MASK_REFRESH_EN
    test_refresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
